kgp_subtractor_pipe: RTL and testbench

- 8-bit pipelined subtractor computing diff = a - b - bin, using the same Kill/Propagate/Generate prefix-carry structure as the team's KGP adder.
- Accepts operands over a valid/ready handshake and returns diff and borrow three cycles later.
- Supports backpressure, so it can sit between an operand source and a result sink in datapath blocks.

---
 rtl/kgp_pkg.sv | 19 +
 rtl/kgp_prefix_cell.sv | 20 ++
 rtl/kgp_subtractor_pipe.sv | 159 +++++++++++++++
 tb/tb_kgp_subtractor_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// Shared KGP types and helpers for the prefix-carry subtractor.
// Holds the 2-bit kill/propagate/generate code and the bit encoder.
package kgp_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_K = 2'b00;
  localparam kgp_t KGP_P = 2'b01;
  localparam kgp_t KGP_G = 2'b11;

  // Both 0 -> K, both 1 -> G, else P.
  function automatic kgp_t kgp_encode(
    input logic x,
    input logic y
  );
    return {x & y, x | y};
  endfunction

endpackage

// File: rtl/kgp_prefix_cell.sv
// Combinational KGP prefix node: combines an upper span over a lower one.
// Ports: upper_i, lower_i (kgp_t) in; comb_o (kgp_t) out.
module kgp_prefix_cell
  import kgp_pkg::*;
(
  input  kgp_t upper_i,
  input  kgp_t lower_i,
  output kgp_t comb_o
);

  always_comb begin
    comb_o = lower_i;
    unique case (1'b1)
      (upper_i == KGP_K): comb_o = KGP_K;
      (upper_i == KGP_G): comb_o = KGP_G;
      default:            comb_o = lower_i;
    endcase
  end

endmodule

// File: rtl/kgp_subtractor_pipe.sv
// 3-stage KGP prefix subtractor, diff = a - b - bin, valid/ready handshake.
// Ports: clk, rst, in_valid/in_ready, a, b, bin, out_valid/out_ready,
// diff, bout; zero/neg/ovf flags when KGP_SUB_FLAGS_EN is defined.
module kgp_subtractor_pipe
  import kgp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef KGP_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  logic stall;
  logic v1_q, v2_q, v3_q;

  assign stall     = v3_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;

  // Stage 1: operand codes. Position 0 carries cin = ~bin.
  kgp_t [WIDTH:0]   c0;
  kgp_t [WIDTH:0]   c1_q;
  logic [WIDTH-1:0] a1_q, b1_q;

  always_comb begin
    c0[0] = bin ? KGP_K : KGP_G;
    for (int i = 0; i < WIDTH; i++) begin
      c0[i+1] = kgp_encode(a[i], ~b[i]);
    end
  end

  // Stage 2: spans 1 and 2 over positions 0..WIDTH-1.
  kgp_t [WIDTH-1:0] l1;
  kgp_t [WIDTH-1:0] l2;
  kgp_t [WIDTH-1:0] p2_q;
  kgp_t             top2_q;
  logic [WIDTH-1:0] a2_q, b2_q;

  assign l1[0] = c1_q[0];
  for (genvar j = 1; j < WIDTH; j++) begin : g_l1
    kgp_prefix_cell u_c (
      .upper_i(c1_q[j]),
      .lower_i(c1_q[j-1]),
      .comb_o (l1[j])
    );
  end

  assign l2[1:0] = l1[1:0];
  for (genvar j = 2; j < WIDTH; j++) begin : g_l2
    kgp_prefix_cell u_c (
      .upper_i(l1[j]),
      .lower_i(l1[j-2]),
      .comb_o (l2[j])
    );
  end

  // Stage 3: span 4 gives the carry into every bit.
  kgp_t [WIDTH-1:0] l3;
  kgp_t             co;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] diff_d;
  logic             bout_d;

  assign l3[3:0] = p2_q[3:0];
  for (genvar j = 4; j < WIDTH; j++) begin : g_l3
    kgp_prefix_cell u_c (
      .upper_i(p2_q[j]),
      .lower_i(p2_q[j-4]),
      .comb_o (l3[j])
    );
  end

  // Carry-out folds the top bit's code over the full carry into it.
  kgp_prefix_cell u_co (
    .upper_i(top2_q),
    .lower_i(l3[WIDTH-1]),
    .comb_o (co)
  );

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = (l3[i] == KGP_G);
    end
  end

  assign diff_d = a2_q ^ ~b2_q ^ carry;
  assign bout_d = (co != KGP_G);

  always_ff @(posedge clk) begin
    if (!stall) begin
      c1_q   <= c0;
      a1_q   <= a;
      b1_q   <= b;
      p2_q   <= l2;
      top2_q <= c1_q[WIDTH];
      a2_q   <= a1_q;
      b2_q   <= b1_q;
    end
  end

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (!stall) begin
      v1_q   <= in_valid;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

`ifdef KGP_SUB_FLAGS_EN
  logic zero_q, neg_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (!stall) begin
      zero_q <= (diff_d == '0);
      neg_q  <= diff_d[WIDTH-1];
      ovf_q  <= (a2_q[WIDTH-1] ^ b2_q[WIDTH-1])
              & (a2_q[WIDTH-1] ^ diff_d[WIDTH-1]);
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_kgp_subtractor_pipe.sv
// Scoreboard bench for kgp_subtractor_pipe.
// Directed, stall, reset and random streams against a reference model.
module tb_kgp_subtractor_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
`ifdef KGP_SUB_FLAGS_EN
  logic       zero, neg, ovf;
`endif

  kgp_subtractor_pipe #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef KGP_SUB_FLAGS_EN
    ,
    .zero     (zero),
    .neg      (neg),
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Packed result: {ovf, neg, zero, bout, diff}.
  function automatic logic [11:0] model(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       c
  );
    logic [8:0] r;
    logic       z, n, o;
    r = {1'b0, x} - {1'b0, y} - {8'b0, c};
    z = (r[7:0] == 8'h00);
    n = r[7];
    o = (x[7] ^ y[7]) & (x[7] ^ r[7]);
`ifdef KGP_SUB_FLAGS_EN
    return {o, n, z, ~r[8] ? 1'b0 : 1'b1, r[7:0]};
`else
    return {3'b000, r[8], r[7:0]} | {o & 1'b0, n & 1'b0, z & 1'b0, 9'h0};
`endif
  endfunction

  logic [11:0] sbq[$];
  int          accepted = 0;
  int          retired  = 0;
  logic        held = 1'b0;
  logic [8:0]  hval;

  always @(negedge clk) begin
    logic [11:0] obs;
    logic [11:0] e;
`ifdef KGP_SUB_FLAGS_EN
    obs = {ovf, neg, zero, bout, diff};
`else
    obs = {3'b000, bout, diff};
`endif
    if (rst) begin
      sbq.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_diff", 32'({bout, diff}), 32'(hval));
      end
      if (out_valid && !out_ready)
        chk("stall_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        retired++;
        if (sbq.size() == 0) begin
          chk("sb_empty", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          chk("result", 32'(obs), 32'(e));
        end
      end
      if (in_valid && in_ready) begin
        accepted++;
        sbq.push_back(model(a, b, bin));
      end
      held = out_valid && !out_ready;
      hval = {bout, diff};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       c
  );
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    a = x;
    b = y;
    bin = c;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) break;
    end
    chk("send_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic lat_send(
    input logic [7:0] x,
    input logic [7:0] y,
    input logic       c
  );
    int n;
    send(x, y, c);
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  logic [7:0] sa[5] = '{8'h01, 8'hAA, 8'h33, 8'h00, 8'hFF};
  logic [7:0] sb[5] = '{8'h02, 8'h55, 8'h44, 8'h00, 8'hFF};
  logic       sc[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int idx, r0, a0, cyc;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);

    lat_send(8'h05, 8'h03, 1'b0);
    chk("first_diff", 32'(diff), 32'h02);
    chk("first_bout", 32'(bout), 32'd0);
    drain();
    send(8'h00, 8'h01, 1'b0);
    send(8'h10, 8'h0F, 1'b1);
    send(8'h80, 8'h01, 1'b0);
    send(8'h7F, 8'hFF, 1'b0);
    drain();

    r0 = retired;
    idx = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid = (idx < 5);
      if (idx < 5) begin
        a = sa[idx];
        b = sb[idx];
        bin = sc[idx];
      end
      @(negedge clk);
      if (cyc >= 4 && cyc <= 6)
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) idx++;
      step();
      if (idx == 5 && sbq.size() == 0) break;
    end
    in_valid = 1'b0;
    drain();
    chk("stall_retired", 32'(retired - r0), 32'd5);
    chk("stall_last_diff", 32'(diff), 32'hFF);
    chk("stall_last_bout", 32'(bout), 32'd1);

    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'h44;
    b = 8'h11;
    bin = 1'b0;
    step();
    a = 8'h21;
    b = 8'h12;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    r0 = retired;
    repeat (4) begin
      step();
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    lat_send(8'h12, 8'h34, 1'b1);
    drain();
    chk("post_rst_retired", 32'(retired - r0), 32'd1);

    r0 = retired;
    a0 = accepted;
    for (cyc = 0; cyc < 60000; cyc++) begin
      if (accepted - a0 >= 10000) break;
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid = ($urandom_range(0, 9) < 8);
      a = 8'($urandom);
      b = 8'($urandom);
      bin = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("rand_count", 32'(accepted - a0), 32'd10000);
    drain();
    chk("rand_retired", 32'(retired - r0), 32'(accepted - a0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
